// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects, load-use stall, branch-flush sequencer, memory-busy freeze
// and saturating stall/flush event counters for the five-stage pipeline.
module fwd_hazard_ctrl #(
  parameter int REG_AW       = 4,
  parameter bit ZERO_REG_EN  = 1'b1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rs,
  input  logic              fd_uses_rt,
  input  logic              fd_mem_write,
  input  logic [REG_AW-1:0] de_rs,
  input  logic [REG_AW-1:0] de_rt,
  input  logic [REG_AW-1:0] de_dst,
  input  logic              de_reg_write,
  input  logic              de_mem_read,
  input  logic [REG_AW-1:0] xm_dst,
  input  logic [REG_AW-1:0] xm_rt,
  input  logic              xm_reg_write,
  input  logic              xm_mem_write,
  input  logic [REG_AW-1:0] mw_dst,
  input  logic              mw_reg_write,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic [1:0]        a_sel,
  output logic [1:0]        b_sel,
  output logic              b_m2m,
  output logic              stall_fd,
  output logic              bubble_de,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             lu;

  function automatic logic live(input logic [REG_AW-1:0] r);
    return !ZERO_REG_EN || (r != '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (xm_reg_write && live(xm_dst) && (xm_dst == src)) return 2'b01;
    if (mw_reg_write && live(mw_dst) && (mw_dst == src)) return 2'b10;
    return 2'b00;
  endfunction

  // A store whose data operand is the only match is covered by M2M forwarding.
  always_comb begin
    lu = 1'b0;
    if (de_mem_read && de_reg_write && live(de_dst)) begin
      lu = (fd_uses_rs && (de_dst == fd_rs)) ||
           (fd_uses_rt && (de_dst == fd_rt) && !fd_mem_write);
    end
  end

  always_comb begin
    a_sel = 2'b00;
    b_sel = 2'b00;
    b_m2m = 1'b0;
    if (!rst) begin
      a_sel = fwd_sel(de_rs);
      b_sel = fwd_sel(de_rt);
      b_m2m = xm_mem_write && mw_reg_write && live(mw_dst) && (mw_dst == xm_rt);
    end
  end

  always_comb begin
    freeze    = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    stall_fd  = 1'b0;
    bubble_de = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        freeze = 1'b1;
      end else if (state == FLUSH) begin
        flush_fd = 1'b1;
      end else if (branch_taken) begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end else if (lu) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
      end
    end
  end

  assign stall_cnt = rst ? '0 : stall_q;
  assign flush_cnt = rst ? '0 : flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= sat_inc(stall_q, freeze | stall_fd);
      flush_q <= sat_inc(flush_q, flush_fd);
      if (!mem_busy) begin
        unique case (state)
          RUN: begin
            if (branch_taken && (FLUSH_CYCLES > 1)) begin
              state <= FLUSH;
              cnt   <= FLUSH_INIT;
            end
          end
          FLUSH: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized and directed bench for fwd_hazard_ctrl against a pending-flush
// count / integer-counter reference model.
module tb_fwd_hazard_ctrl;

  localparam int REG_AW = 4;
  localparam bit ZR     = 1'b1;
  localparam int FC     = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] fd_rs, fd_rt, de_rs, de_rt, de_dst, xm_dst, xm_rt, mw_dst;
  logic fd_uses_rs, fd_uses_rt, fd_mem_write, de_reg_write, de_mem_read;
  logic xm_reg_write, xm_mem_write, mw_reg_write, branch_taken, mem_busy;
  logic [1:0] a_sel, b_sel;
  logic b_m2m, stall_fd, bubble_de, flush_fd, flush_de, freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .ZERO_REG_EN(ZR), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .fd_mem_write(fd_mem_write),
    .de_rs(de_rs), .de_rt(de_rt), .de_dst(de_dst), .de_reg_write(de_reg_write),
    .de_mem_read(de_mem_read),
    .xm_dst(xm_dst), .xm_rt(xm_rt), .xm_reg_write(xm_reg_write), .xm_mem_write(xm_mem_write),
    .mw_dst(mw_dst), .mw_reg_write(mw_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .a_sel(a_sel), .b_sel(b_sel), .b_m2m(b_m2m), .stall_fd(stall_fd), .bubble_de(bubble_de),
    .flush_fd(flush_fd), .flush_de(flush_de), .freeze(freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit live(input logic [REG_AW-1:0] r);
    return !ZR || r != 0;
  endfunction

  function automatic int sel_for(input logic [REG_AW-1:0] src);
    if (xm_reg_write && live(xm_dst) && xm_dst == src) return 1;
    if (mw_reg_write && live(mw_dst) && mw_dst == src) return 2;
    return 0;
  endfunction

  // Check all outputs against the model this cycle, then advance the model on the edge.
  task automatic step();
    int ea, eb, em, efz, eff, efd, est;
    bit lu;
    @(negedge clk);
    ea = 0; eb = 0; em = 0; efz = 0; eff = 0; efd = 0; est = 0;
    lu = de_mem_read && de_reg_write && live(de_dst) &&
         ((fd_uses_rs && de_dst == fd_rs) || (fd_uses_rt && de_dst == fd_rt && !fd_mem_write));
    if (!rst) begin
      ea = sel_for(de_rs);
      eb = sel_for(de_rt);
      em = (xm_mem_write && mw_reg_write && live(mw_dst) && mw_dst == xm_rt) ? 1 : 0;
      if (mem_busy) efz = 1;
      else if (m_left > 0) eff = 1;
      else if (branch_taken) begin eff = 1; efd = 1; end
      else if (lu) est = 1;
    end
    chk("a_sel", a_sel, ea);
    chk("b_sel", b_sel, eb);
    chk("b_m2m", b_m2m, em);
    chk("freeze", freeze, efz);
    chk("flush_fd", flush_fd, eff);
    chk("flush_de", flush_de, efd);
    chk("stall_fd", stall_fd, est);
    chk("bubble_de", bubble_de, est);
    chk("stall_cnt", stall_cnt, rst ? 0 : m_stall);
    chk("flush_cnt", flush_cnt, rst ? 0 : m_flush);
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if ((efz || est) && m_stall < CMAX) m_stall++;
      if (eff && m_flush < CMAX) m_flush++;
      if (!mem_busy) begin
        if (m_left > 0) m_left--;
        else if (branch_taken) m_left = FC - 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    {fd_rs, fd_rt, de_rs, de_rt, de_dst, xm_dst, xm_rt, mw_dst} = '0;
    {fd_uses_rs, fd_uses_rt, fd_mem_write, de_reg_write, de_mem_read} = '0;
    {xm_reg_write, xm_mem_write, mw_reg_write, branch_taken, mem_busy} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nflush;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    chk("rst_freeze", freeze, 0);
    rst = 1'b0;

    // Forwarding
    xm_reg_write = 1; xm_dst = 5; mw_reg_write = 1; mw_dst = 5; de_rs = 5; de_rt = 3;
    #1; chk("fwd_x2x_a", a_sel, 1); chk("fwd_x2x_b", b_sel, 0); step();
    xm_reg_write = 0;
    #1; chk("fwd_m2x_a", a_sel, 2); step();
    mw_dst = 0; de_rs = 0;
    #1; chk("fwd_zero_a", a_sel, 0); step();
    clear_inputs();

    // Load-use and store exemption
    do_reset();
    de_mem_read = 1; de_reg_write = 1; de_dst = 4; fd_rs = 4; fd_uses_rs = 1;
    #1; chk("lu_stall", stall_fd, 1); chk("lu_bubble", bubble_de, 1); step();
    de_mem_read = 0;
    #1; chk("lu_one_cycle", stall_fd, 0); chk("lu_cnt", stall_cnt, 1); step();
    de_mem_read = 1; fd_uses_rs = 0; fd_mem_write = 1; fd_rt = 4; fd_uses_rt = 1; fd_rs = 2;
    #1; chk("lu_store_exempt", stall_fd, 0); step();
    clear_inputs();

    // Store M2M
    xm_mem_write = 1; xm_rt = 7; mw_reg_write = 1; mw_dst = 7;
    #1; chk("m2m_hit", b_m2m, 1); step();
    mw_dst = 6;
    #1; chk("m2m_miss", b_m2m, 0); step();
    clear_inputs();

    // Branch flush with a mid-sequence freeze
    do_reset();
    nflush = 0;
    branch_taken = 1;
    #1; chk("br_flush_de", flush_de, 1); nflush += flush_fd; step();
    branch_taken = 0; mem_busy = 1;
    #1; chk("br_freeze", freeze, 1); nflush += flush_fd; step();
    #1; nflush += flush_fd; step();
    mem_busy = 0;
    for (int i = 0; i < 3; i++) begin
      #1; nflush += flush_fd;
      if (i < 2) chk("br_no_de", flush_de, 0);
      step();
    end
    chk("br_total", nflush, 3);
    chk("br_flush_cnt", flush_cnt, 3);

    // Priority
    mem_busy = 1; branch_taken = 1; de_mem_read = 1; de_reg_write = 1; de_dst = 4;
    fd_rs = 4; fd_uses_rs = 1;
    #1; chk("prio_freeze", freeze, 1); chk("prio_flush", flush_fd, 0); step();
    clear_inputs();

    // Reset mid-flush
    branch_taken = 1; step();
    branch_taken = 0; rst = 1;
    #1; chk("rst_flush", flush_fd, 0); step();
    rst = 0;
    #1; chk("rst_no_residual", flush_fd, 0); chk("rst_cnt", flush_cnt, 0); step();

    // Saturation
    do_reset();
    mem_busy = 1;
    repeat (20) step();
    mem_busy = 0;
    #1; chk("sat_stall_cnt", stall_cnt, CMAX); step();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      fd_rs        = REG_AW'($urandom_range(0, 3));
      fd_rt        = REG_AW'($urandom_range(0, 3));
      de_rs        = REG_AW'($urandom_range(0, 3));
      de_rt        = REG_AW'($urandom_range(0, 3));
      de_dst       = REG_AW'($urandom_range(0, 3));
      xm_dst       = REG_AW'($urandom_range(0, 3));
      xm_rt        = REG_AW'($urandom_range(0, 3));
      mw_dst       = REG_AW'($urandom_range(0, 3));
      fd_uses_rs   = $urandom_range(0, 1) == 1;
      fd_uses_rt   = $urandom_range(0, 1) == 1;
      fd_mem_write = $urandom_range(0, 2) == 0;
      de_reg_write = $urandom_range(0, 3) != 0;
      de_mem_read  = $urandom_range(0, 1) == 1;
      xm_reg_write = $urandom_range(0, 1) == 1;
      xm_mem_write = $urandom_range(0, 1) == 1;
      mw_reg_write = $urandom_range(0, 1) == 1;
      branch_taken = $urandom_range(0, 7) == 0;
      mem_busy     = $urandom_range(0, 4) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
